// File: rtl/detector_jogada.sv
// Button conditioner: debounces the four player buttons, latches the accepted play,
// pulses once per press, flags multi-button plays and runs the per-play timeout.
module detector_jogada #(
   parameter int unsigned DEBOUNCE_CYCLES = 10,
   parameter int unsigned TIMEOUT_CYCLES  = 5000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       habilita,
   input  logic       zera_timeout,
   input  logic [3:0] botoes,
   output logic [3:0] jogada,
   output logic       jogada_feita,
   output logic       tem_jogada,
   output logic       multipla,
   output logic       timeout,
   output logic [1:0] db_estado
);

   localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      OCIOSO       = 2'd0,
      FILTRA_PRESS = 2'd1,
      PRESSIONADO  = 2'd2,
      FILTRA_SOLTA = 2'd3
   } estado_t;

   estado_t       state_q, state_d;
   logic [3:0]    cand_q, cand_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [TW-1:0] tcnt_q, tcnt_d;
   logic [3:0]    jogada_q, jogada_d;
   logic          multipla_q, multipla_d;
   logic          jogada_feita_q, jogada_feita_d;
   logic          tem_jogada_q, tem_jogada_d;
   logic          timeout_q, timeout_d;

   // Debounce FSM: a level must be seen DEBOUNCE_CYCLES times in a row to be accepted
   always_comb begin
      state_d        = state_q;
      cand_d         = cand_q;
      cnt_d          = cnt_q;
      jogada_d       = jogada_q;
      multipla_d     = multipla_q;
      jogada_feita_d = 1'b0;
      case (state_q)
         OCIOSO: begin
            if (habilita && (botoes != 4'b0000)) begin
               state_d = FILTRA_PRESS;
               cand_d  = botoes;
               cnt_d   = '0;
            end
         end
         FILTRA_PRESS: begin
            if (!habilita || (botoes == 4'b0000)) begin
               state_d = OCIOSO;
            end else if (botoes != cand_q) begin
               cand_d = botoes;
               cnt_d  = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d        = PRESSIONADO;
               jogada_d       = cand_q;
               multipla_d     = ($countones(cand_q) > 1);
               jogada_feita_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         PRESSIONADO: begin
            if (botoes == 4'b0000) begin
               state_d = FILTRA_SOLTA;
               cnt_d   = '0;
            end
         end
         FILTRA_SOLTA: begin
            // A bounce during release returns to the held state without a new pulse
            if (botoes != 4'b0000) begin
               state_d = PRESSIONADO;
            end else if (cnt_q == CNT_LAST) begin
               state_d = OCIOSO;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = OCIOSO;
      endcase
      tem_jogada_d = (state_d == PRESSIONADO) || (state_d == FILTRA_SOLTA);
   end

   // Timeout counter: clear wins, an accepted play restarts, counts only while waiting
   always_comb begin
      tcnt_d    = tcnt_q;
      timeout_d = timeout_q;
      if (zera_timeout) begin
         tcnt_d    = '0;
         timeout_d = 1'b0;
      end else if (jogada_feita_q) begin
         tcnt_d = '0;
      end else if (habilita && ((state_q == OCIOSO) || (state_q == FILTRA_PRESS))) begin
         if (tcnt_q == TCNT_LAST) begin
            timeout_d = 1'b1;
         end else begin
            tcnt_d = tcnt_q + TW'(1);
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q        <= OCIOSO;
         cand_q         <= '0;
         cnt_q          <= '0;
         tcnt_q         <= '0;
         jogada_q       <= '0;
         multipla_q     <= 1'b0;
         jogada_feita_q <= 1'b0;
         tem_jogada_q   <= 1'b0;
         timeout_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         cand_q         <= cand_d;
         cnt_q          <= cnt_d;
         tcnt_q         <= tcnt_d;
         jogada_q       <= jogada_d;
         multipla_q     <= multipla_d;
         jogada_feita_q <= jogada_feita_d;
         tem_jogada_q   <= tem_jogada_d;
         timeout_q      <= timeout_d;
      end
   end

   assign jogada       = jogada_q;
   assign jogada_feita = jogada_feita_q;
   assign tem_jogada   = tem_jogada_q;
   assign multipla     = multipla_q;
   assign timeout      = timeout_q;
   assign db_estado    = state_q;

endmodule

// File: tb/tb_detector_jogada.sv
// Directed bench for detector_jogada with DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=20.
module tb_detector_jogada;

   logic       clock = 1'b0;
   logic       reset;
   logic       habilita;
   logic       zera_timeout;
   logic [3:0] botoes;
   logic [3:0] jogada;
   logic       jogada_feita;
   logic       tem_jogada;
   logic       multipla;
   logic       timeout;
   logic [1:0] db_estado;

   int total = 0;
   int bad   = 0;

   detector_jogada #(
      .DEBOUNCE_CYCLES(4),
      .TIMEOUT_CYCLES (20)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .habilita    (habilita),
      .zera_timeout(zera_timeout),
      .botoes      (botoes),
      .jogada      (jogada),
      .jogada_feita(jogada_feita),
      .tem_jogada  (tem_jogada),
      .multipla    (multipla),
      .timeout     (timeout),
      .db_estado   (db_estado)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0; habilita = 1'b0; zera_timeout = 1'b0; botoes = 4'b0000;
      tick(); tick();
      total++;
      if ({jogada, jogada_feita, tem_jogada, multipla, timeout, db_estado} !== 10'b0) begin
         bad++;
         $display("FAIL reset_hold got=%b exp=%b",
                  {jogada, jogada_feita, tem_jogada, multipla, timeout, db_estado}, 10'b0);
      end
      reset = 1'b1;
      tick();
      total++;
      if ({jogada, jogada_feita, tem_jogada, multipla, timeout, db_estado} !== 10'b0) begin
         bad++;
         $display("FAIL reset_release got=%b exp=%b",
                  {jogada, jogada_feita, tem_jogada, multipla, timeout, db_estado}, 10'b0);
      end
   endtask

   task automatic test_single_press();
      int pulses = 0;
      int pulse_at = 0;
      int fall_at = 0;
      habilita = 1'b1;
      botoes = 4'b0100;
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (jogada_feita === 1'b1) begin
            pulses++;
            if (pulse_at == 0) pulse_at = i;
         end
      end
      total++;
      if (pulses != 1) begin bad++; $display("FAIL press_pulses got=%0d exp=1", pulses); end
      total++;
      if (pulse_at != 5) begin bad++; $display("FAIL press_latency got=%0d exp=5", pulse_at); end
      total++;
      if (jogada !== 4'b0100) begin bad++; $display("FAIL press_jogada got=%b exp=0100", jogada); end
      total++;
      if (multipla !== 1'b0) begin bad++; $display("FAIL press_multipla got=%b exp=0", multipla); end
      total++;
      if (db_estado !== 2'd2 || tem_jogada !== 1'b1) begin
         bad++;
         $display("FAIL press_held got=%0d/%b exp=2/1", db_estado, tem_jogada);
      end
      botoes = 4'b0000;
      for (int j = 1; j <= 8; j++) begin
         tick();
         if (tem_jogada === 1'b0 && fall_at == 0) fall_at = j;
      end
      total++;
      if (fall_at != 5) begin bad++; $display("FAIL release_latency got=%0d exp=5", fall_at); end
      total++;
      if (jogada !== 4'b0100 || db_estado !== 2'd0) begin
         bad++;
         $display("FAIL release_hold got=%b/%0d exp=0100/0", jogada, db_estado);
      end
   endtask

   task automatic test_bounce();
      int pulses = 0;
      for (int i = 0; i < 12; i++) begin
         botoes = ((i / 2) % 2 == 0) ? 4'b0100 : 4'b0000;
         tick();
         if (jogada_feita === 1'b1) pulses++;
      end
      total++;
      if (pulses != 0) begin bad++; $display("FAIL bounce_no_pulse got=%0d exp=0", pulses); end
      botoes = 4'b0100;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (jogada_feita === 1'b1) pulses++;
      end
      total++;
      if (pulses != 1) begin bad++; $display("FAIL bounce_stable_pulse got=%0d exp=1", pulses); end
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         botoes = ((i / 2) % 2 == 0) ? 4'b0000 : 4'b0100;
         tick();
         if (jogada_feita === 1'b1) pulses++;
      end
      botoes = 4'b0000;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (jogada_feita === 1'b1) pulses++;
      end
      total++;
      if (pulses != 0) begin bad++; $display("FAIL release_bounce_pulse got=%0d exp=0", pulses); end
      total++;
      if (db_estado !== 2'd0 || tem_jogada !== 1'b0) begin
         bad++;
         $display("FAIL release_bounce_idle got=%0d/%b exp=0/0", db_estado, tem_jogada);
      end
   endtask

   task automatic test_multi();
      int pulses = 0;
      botoes = 4'b0011;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (jogada_feita === 1'b1) pulses++;
      end
      total++;
      if (jogada !== 4'b0011) begin bad++; $display("FAIL multi_jogada got=%b exp=0011", jogada); end
      total++;
      if (multipla !== 1'b1) begin bad++; $display("FAIL multi_flag got=%b exp=1", multipla); end
      total++;
      if (pulses != 1) begin bad++; $display("FAIL multi_pulses got=%0d exp=1", pulses); end
      botoes = 4'b0000;
      for (int i = 0; i < 6; i++) tick();
   endtask

   task automatic test_timeout();
      zera_timeout = 1'b1; tick(); zera_timeout = 1'b0;
      habilita = 1'b0;
      for (int i = 0; i < 30; i++) tick();
      total++;
      if (timeout !== 1'b0) begin bad++; $display("FAIL timeout_paused got=%b exp=0", timeout); end
      habilita = 1'b1;
      for (int i = 0; i < 19; i++) tick();
      total++;
      if (timeout !== 1'b0) begin bad++; $display("FAIL timeout_early got=%b exp=0", timeout); end
      tick();
      total++;
      if (timeout !== 1'b1) begin bad++; $display("FAIL timeout_set got=%b exp=1", timeout); end
      for (int i = 0; i < 5; i++) tick();
      total++;
      if (timeout !== 1'b1) begin bad++; $display("FAIL timeout_sticky got=%b exp=1", timeout); end
      zera_timeout = 1'b1; tick(); zera_timeout = 1'b0;
      total++;
      if (timeout !== 1'b0) begin bad++; $display("FAIL timeout_clear got=%b exp=0", timeout); end
      for (int i = 0; i < 19; i++) tick();
      total++;
      if (timeout !== 1'b0) begin bad++; $display("FAIL timeout_restart got=%b exp=0", timeout); end
      zera_timeout = 1'b1; tick(); zera_timeout = 1'b0;
      total++;
      if (timeout !== 1'b0) begin bad++; $display("FAIL timeout_clear_wins got=%b exp=0", timeout); end
      for (int i = 0; i < 5; i++) tick();
      total++;
      if (timeout !== 1'b0) begin bad++; $display("FAIL timeout_after_clear got=%b exp=0", timeout); end
   endtask

   task automatic test_reset_mid_press();
      int pulses = 0;
      int pulse_at = 0;
      botoes = 4'b0001;
      for (int i = 0; i < 6; i++) tick();
      total++;
      if (tem_jogada !== 1'b1 || jogada !== 4'b0001) begin
         bad++;
         $display("FAIL midreset_pre got=%b/%b exp=1/0001", tem_jogada, jogada);
      end
      #2 reset = 1'b0;
      #1;
      total++;
      if ({jogada, jogada_feita, tem_jogada, multipla, timeout, db_estado} !== 10'b0) begin
         bad++;
         $display("FAIL midreset_async got=%b exp=%b",
                  {jogada, jogada_feita, tem_jogada, multipla, timeout, db_estado}, 10'b0);
      end
      tick(); tick();
      reset = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         tick();
         if (jogada_feita === 1'b1) begin
            pulses++;
            if (pulse_at == 0) pulse_at = i;
         end
      end
      total++;
      if (pulses != 1 || pulse_at != 5) begin
         bad++;
         $display("FAIL midreset_reaccept got=%0d@%0d exp=1@5", pulses, pulse_at);
      end
      total++;
      if (jogada !== 4'b0001) begin bad++; $display("FAIL midreset_jogada got=%b exp=0001", jogada); end
   endtask

   initial begin
      test_reset();
      test_single_press();
      test_bounce();
      test_multi();
      test_timeout();
      test_reset_mid_press();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
